// File: rtl/mem_dp_pipe.sv
// True dual-port byte-lane RAM with parametrised output pipelining, mixed-port
// read-during-write behaviour, per-port read-valid tracking and collision flag.
module mem_dp_pipe #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 8,
  parameter int BYTE_W    = 8,
  parameter int OUT_REG   = 0,
  parameter int RDW_MIXED = 0
) (
  input  logic                       clock,
  input  logic                       aclr_n,
  input  logic [ADDR_W-1:0]          address_a,
  input  logic [ADDR_W-1:0]          address_b,
  input  logic [DATA_W-1:0]          data_a,
  input  logic [DATA_W-1:0]          data_b,
  input  logic [DATA_W/BYTE_W-1:0]   byteena_a,
  input  logic [DATA_W/BYTE_W-1:0]   byteena_b,
  input  logic                       wren_a,
  input  logic                       wren_b,
  input  logic                       rden_a,
  input  logic                       rden_b,
  output logic [DATA_W-1:0]          q_a,
  output logic [DATA_W-1:0]          q_b,
  output logic                       q_valid_a,
  output logic                       q_valid_b,
  output logic                       collision
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  if (DATA_W % BYTE_W != 0) begin : g_bad_width
    $error("mem_dp_pipe: DATA_W must be a multiple of BYTE_W");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [NB-1:0]     be_a_eff;
  logic [NB-1:0]     be_b_eff;
  logic              same_addr;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] q1_a;
  logic [DATA_W-1:0] q1_b;
  logic              v1_a;
  logic              v1_b;

  // Overlay the enabled lanes of wdata onto base.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] base,
                                              input logic [DATA_W-1:0] wdata,
                                              input logic [NB-1:0]     be);
    merge = base;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merge[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
    end
  endfunction

  // Read-side view of the word after this edge's writes. Own-port writes always
  // show through; the other port's write only when RDW_MIXED selects new data.
  // B is applied before A so that A wins lanes both ports enable.
  always_comb begin
    be_a_eff  = wren_a ? byteena_a : '0;
    be_b_eff  = wren_b ? byteena_b : '0;
    same_addr = (address_a == address_b);
    rd_a      = merge(mem[address_a], data_b,
                      (RDW_MIXED != 0 && same_addr) ? be_b_eff : '0);
    rd_a      = merge(rd_a, data_a, be_a_eff);
    rd_b      = merge(mem[address_b], data_b, be_b_eff);
    rd_b      = merge(rd_b, data_a,
                      (RDW_MIXED != 0 && same_addr) ? be_a_eff : '0);
  end

  // NOTE: the array has no reset so it maps onto block RAM; contents survive aclr_n.
  always_ff @(posedge clock) begin
    if (aclr_n) begin
      for (int i = 0; i < NB; i++) begin
        if (be_b_eff[i]) mem[address_b][i*BYTE_W +: BYTE_W] <= data_b[i*BYTE_W +: BYTE_W];
        if (be_a_eff[i]) mem[address_a][i*BYTE_W +: BYTE_W] <= data_a[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // First pipeline stage: q holds when no read is issued, valid marks each slot.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      q1_a      <= '0;
      q1_b      <= '0;
      v1_a      <= 1'b0;
      v1_b      <= 1'b0;
      collision <= 1'b0;
    end else begin
      v1_a      <= rden_a;
      v1_b      <= rden_b;
      collision <= wren_a && wren_b && same_addr;
      if (rden_a) q1_a <= rd_a;
      if (rden_b) q1_b <= rd_b;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
        q_a       <= '0;
        q_b       <= '0;
        q_valid_a <= 1'b0;
        q_valid_b <= 1'b0;
      end else begin
        q_a       <= q1_a;
        q_b       <= q1_b;
        q_valid_a <= v1_a;
        q_valid_b <= v1_b;
      end
    end
  end else begin : g_no_out_reg
    assign q_a       = q1_a;
    assign q_b       = q1_b;
    assign q_valid_a = v1_a;
    assign q_valid_b = v1_b;
  end

endmodule

// File: tb/tb_mem_dp_pipe.sv
// Directed bench for mem_dp_pipe: two instances on shared stimulus, one with
// latency 1 / old-data RDW, the other with latency 2 / new-data RDW.
module tb_mem_dp_pipe;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NB = 4;

  logic          clock = 1'b0;
  logic          aclr_n;
  logic [AW-1:0] address_a, address_b;
  logic [DW-1:0] data_a, data_b;
  logic [NB-1:0] byteena_a, byteena_b;
  logic          wren_a, wren_b, rden_a, rden_b;

  logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;
  logic          qv_a0, qv_b0, qv_a1, qv_b1;
  logic          coll0, coll1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  mem_dp_pipe #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(8), .OUT_REG(0), .RDW_MIXED(0)) dut0 (
    .clock(clock), .aclr_n(aclr_n),
    .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b),
    .byteena_a(byteena_a), .byteena_b(byteena_b),
    .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
    .q_a(q_a0), .q_b(q_b0), .q_valid_a(qv_a0), .q_valid_b(qv_b0),
    .collision(coll0)
  );

  mem_dp_pipe #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(8), .OUT_REG(1), .RDW_MIXED(1)) dut1 (
    .clock(clock), .aclr_n(aclr_n),
    .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b),
    .byteena_a(byteena_a), .byteena_b(byteena_b),
    .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
    .q_a(q_a1), .q_b(q_b1), .q_valid_a(qv_a1), .q_valid_b(qv_b1),
    .collision(coll1)
  );

  typedef struct {
    logic          wa;
    logic          ra;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic [NB-1:0] ba;
    logic          wb;
    logic          rb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic [NB-1:0] bb;
    logic [DW-1:0] qa0;   // expected q_a, old-data instance
    logic [DW-1:0] qa1;   // expected q_a, new-data instance
    logic [DW-1:0] qb0;
    logic [DW-1:0] qb1;
    logic          coll;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic idle();
    wren_a = 0; wren_b = 0; rden_a = 0; rden_b = 0;
    address_a = '0; address_b = '0; data_a = '0; data_b = '0;
    byteena_a = '0; byteena_b = '0;
  endtask

  task automatic drive(input vec_t v);
    wren_a = v.wa; rden_a = v.ra; address_a = v.aa; data_a = v.da; byteena_a = v.ba;
    wren_b = v.wb; rden_b = v.rb; address_b = v.ab; data_b = v.db; byteena_b = v.bb;
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return 32'hC0DE_0000 | DW'(i);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        wa ra aa  da            ba       wb ra ab  db            bb       qa0           qa1           qb0           qb1           coll
    vecs[0]  = '{1, 0, 3,  32'hA5A5A5A5, 4'b1111, 0, 0, 0,  32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        32'h0,        0};
    vecs[1]  = '{1, 0, 7,  32'hFFFFFFFF, 4'b1111, 0, 1, 3,  32'h0,        4'b0000, 32'h0,        32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 0};
    vecs[2]  = '{1, 1, 7,  32'h00000000, 4'b0001, 1, 0, 5,  32'h11111111, 4'b1111, 32'hFFFFFF00, 32'hFFFFFF00, 32'h0,        32'h0,        0};
    vecs[3]  = '{1, 0, 5,  32'h22222222, 4'b1111, 0, 1, 5,  32'h0,        4'b0000, 32'h0,        32'h0,        32'h11111111, 32'h22222222, 0};
    vecs[4]  = '{0, 1, 7,  32'h0,        4'b0000, 0, 1, 5,  32'h0,        4'b0000, 32'hFFFFFF00, 32'hFFFFFF00, 32'h22222222, 32'h22222222, 0};
    vecs[5]  = '{1, 0, 9,  32'h12345678, 4'b1111, 0, 0, 0,  32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        32'h0,        0};
    vecs[6]  = '{1, 0, 9,  32'hAAAAAAAA, 4'b0011, 1, 0, 9,  32'hBBBBBBBB, 4'b0110, 32'h0,        32'h0,        32'h0,        32'h0,        1};
    vecs[7]  = '{0, 1, 9,  32'h0,        4'b0000, 0, 1, 9,  32'h0,        4'b0000, 32'h12BBAAAA, 32'h12BBAAAA, 32'h12BBAAAA, 32'h12BBAAAA, 0};
    vecs[8]  = '{1, 0, 10, 32'hCAFEF00D, 4'b1111, 1, 0, 11, 32'h0BADBEEF, 4'b1111, 32'h0,        32'h0,        32'h0,        32'h0,        0};
    vecs[9]  = '{0, 1, 11, 32'h0,        4'b0000, 0, 1, 10, 32'h0,        4'b0000, 32'h0BADBEEF, 32'h0BADBEEF, 32'hCAFEF00D, 32'hCAFEF00D, 0};
    vecs[10] = '{0, 1, 5,  32'h0,        4'b0000, 1, 0, 5,  32'h33333333, 4'b1100, 32'h22222222, 32'h33332222, 32'h0,        32'h0,        0};
    vecs[11] = '{0, 1, 5,  32'h0,        4'b0000, 0, 1, 3,  32'h0,        4'b0000, 32'h33332222, 32'h33332222, 32'hA5A5A5A5, 32'hA5A5A5A5, 0};

    // Reset then idle: every output is zero.
    idle();
    aclr_n = 1'b0;
    step();
    step();
    check("rst q_a0",  q_a0,  0); check("rst q_b0",  q_b0,  0);
    check("rst qv_a0", qv_a0, 0); check("rst qv_b0", qv_b0, 0);
    check("rst coll0", coll0, 0);
    check("rst q_a1",  q_a1,  0); check("rst q_b1",  q_b1,  0);
    check("rst qv_a1", qv_a1, 0); check("rst qv_b1", qv_b1, 0);
    check("rst coll1", coll1, 0);
    aclr_n = 1'b1;

    // Table: latency-1 instance checked against vector i, latency-2 against i-1.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) drive(vecs[i]);
      else        idle();
      step();
      check($sformatf("v%0d qv_a0", i), qv_a0, (i < NV) ? vecs[i].ra : 1'b0);
      check($sformatf("v%0d qv_b0", i), qv_b0, (i < NV) ? vecs[i].rb : 1'b0);
      check($sformatf("v%0d coll0", i), coll0, (i < NV) ? vecs[i].coll : 1'b0);
      check($sformatf("v%0d coll1", i), coll1, (i < NV) ? vecs[i].coll : 1'b0);
      if (i < NV && vecs[i].ra) check($sformatf("v%0d q_a0", i), q_a0, vecs[i].qa0);
      if (i < NV && vecs[i].rb) check($sformatf("v%0d q_b0", i), q_b0, vecs[i].qb0);
      if (i > 0) begin
        check($sformatf("v%0d qv_a1", i-1), qv_a1, vecs[i-1].ra);
        check($sformatf("v%0d qv_b1", i-1), qv_b1, vecs[i-1].rb);
        if (vecs[i-1].ra) check($sformatf("v%0d q_a1", i-1), q_a1, vecs[i-1].qa1);
        if (vecs[i-1].rb) check($sformatf("v%0d q_b1", i-1), q_b1, vecs[i-1].qb1);
      end
    end
    idle();
    step();
    check("post qv_a1", qv_a1, 0);

    // Back-to-back reads on both ports: no bubbles, in order.
    for (int i = 0; i < 16; i++) begin
      wren_a = 1; address_a = AW'(i); data_a = pat(i); byteena_a = '1;
      step();
    end
    idle();
    for (int j = 0; j <= 16; j++) begin
      if (j < 16) begin
        rden_a = 1; address_a = AW'(j);
        rden_b = 1; address_b = AW'(15 - j);
      end else begin
        idle();
      end
      step();
      if (j < 16) begin
        check($sformatf("pipe%0d a0", j), {qv_a0, q_a0}, {1'b1, pat(j)});
        check($sformatf("pipe%0d b0", j), {qv_b0, q_b0}, {1'b1, pat(15 - j)});
      end
      if (j == 0) begin
        check("pipe0 a1 not yet valid", qv_a1, 0);
      end else begin
        check($sformatf("pipe%0d a1", j-1), {qv_a1, q_a1}, {1'b1, pat(j-1)});
        check($sformatf("pipe%0d b1", j-1), {qv_b1, q_b1}, {1'b1, pat(16 - j)});
      end
    end
    step();
    check("pipe end qv_a1", qv_a1, 0);
    check("pipe end qv_b1", qv_b1, 0);

    // Reset with a read in flight in the latency-2 instance.
    wren_a = 1; address_a = 20; data_a = 32'h5555AAAA; byteena_a = '1;
    step();
    idle();
    rden_a = 1; address_a = 20;
    step();
    check("mid read q_a0", {qv_a0, q_a0}, {1'b1, 32'h5555AAAA});
    aclr_n = 1'b0;
    wren_a = 1; data_a = 32'hFFFFFFFF; byteena_a = '1;
    rden_b = 1; address_b = 20;
    #1;
    check("mid rst q_a0",  {qv_a0, q_a0}, 0);
    check("mid rst q_a1",  {qv_a1, q_a1}, 0);
    step();
    check("in rst qv_a1", {qv_a1, qv_b1}, 0);
    check("in rst qv_a0", {qv_a0, qv_b0}, 0);
    step();
    check("in rst q_b0",  {qv_b0, q_b0}, 0);
    idle();
    aclr_n = 1'b1;
    step();
    check("after rst qv0", {qv_a0, qv_b0}, 0);
    check("after rst qv1", {qv_a1, qv_b1}, 0);
    rden_b = 1; address_b = 20;
    step();
    idle();
    check("kept q_b0", {qv_b0, q_b0}, {1'b1, 32'h5555AAAA});
    step();
    check("kept q_b1", {qv_b1, q_b1}, {1'b1, 32'h5555AAAA});
    check("kept qv_b0 drop", qv_b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
